knap_search: RTL and testbench

Sequential exhaustive solver for the item-selection knapsack that the combinational validity checkers in this codebase evaluate. Item values/weights are loaded through a config port; on `start` the block walks all 2^N selections in Gray-code order, updating running value/weight sums with one add or subtract per cycle. It reports the best qualifying selection, meaning the largest value with weight ≤ limit and value ≥ floor. It produces the selection vectors that the checker consumes and sits above it as the search engine.

---
 rtl/knap_search.sv | 182 ++++++++++++++++++
 tb/tb_knap_search.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/knap_search.sv
// ---------------------------------------------------------------------------
// knap_search
//
// Exhaustive knapsack search engine. Item values and weights are loaded
// through the cfg_* port. A start pulse walks all 2^N item selections in
// Gray-code order. Only one bit of the selection changes per step, so the
// running value and weight sums need just one add or subtract per cycle.
// The block reports the best qualifying selection: the largest value whose
// weight is <= max_weight and whose value is >= min_value. On equal values
// the candidate that was evaluated first is kept.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/idx/value/weight  item table write (ignored while busy;
//                            idx >= N is dropped)
//   max_weight, min_value    qualification bounds, latched at start
//   start, abort             begin a search / stop a running search
//   busy, done               state flags (RUN / DONE)
//   found                    at least one qualifying selection this run
//   best_sel/value/weight    best selection so far and its sums
// ---------------------------------------------------------------------------
module knap_search #(
    parameter int N     = 21,
    parameter int IW    = 5,
    parameter int VAL_W = 8,
    parameter int SUM_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [VAL_W-1:0] cfg_value,
    input  logic [VAL_W-1:0] cfg_weight,
    input  logic [SUM_W-1:0] max_weight,
    input  logic [SUM_W-1:0] min_value,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [N-1:0]     best_sel,
    output logic [SUM_W-1:0] best_value,
    output logic [SUM_W-1:0] best_weight
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // k is one bit wider than the selection so the terminal value
    // 2^N-1 can be compared without any wrap ambiguity.
    localparam logic [N:0]  LAST_K = {1'b0, {N{1'b1}}};
    localparam logic [IW:0] N_IDX  = (IW+1)'(N);

    state_t           state_reg;
    logic [N:0]       k_reg;
    logic [N-1:0]     sel_reg;
    logic [SUM_W-1:0] sum_v_reg;
    logic [SUM_W-1:0] sum_w_reg;
    logic [SUM_W-1:0] max_w_reg;
    logic [SUM_W-1:0] min_v_reg;

    logic [VAL_W-1:0] value_reg  [N];
    logic [VAL_W-1:0] weight_reg [N];

    // Table writes are accepted whenever no search is running.
    logic cfg_ok;
    assign cfg_ok = cfg_we && (state_reg != S_RUN) && ({1'b0, cfg_idx} < N_IDX);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_item
            always_ff @(posedge clk) begin
                if (rst) begin
                    value_reg[gi]  <= '0;
                    weight_reg[gi] <= '0;
                end else if (cfg_ok && (cfg_idx == IW'(gi))) begin
                    value_reg[gi]  <= cfg_value;
                    weight_reg[gi] <= cfg_weight;
                end
            end
        end
    endgenerate

    // Next step count and the Gray bit it flips: the position of the
    // lowest set bit of k+1 (k+1 is never zero while advancing).
    logic [N:0]    k_next;
    logic [IW-1:0] tz_idx;
    assign k_next = k_reg + 1'b1;

    always_comb begin
        tz_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (k_next[i]) tz_idx = IW'(i);
        end
    end

    logic             bit_now;
    logic [SUM_W-1:0] item_v;
    logic [SUM_W-1:0] item_w;
    logic             qualifies;
    logic             better;

    assign bit_now   = sel_reg[tz_idx];
    assign item_v    = {{(SUM_W-VAL_W){1'b0}}, value_reg[tz_idx]};
    assign item_w    = {{(SUM_W-VAL_W){1'b0}}, weight_reg[tz_idx]};
    assign qualifies = (sum_w_reg <= max_w_reg) && (sum_v_reg >= min_v_reg);
    // Strict greater-than keeps the earlier candidate on a tie.
    assign better    = qualifies && (!found || (sum_v_reg > best_value));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            best_sel    <= '0;
            best_value  <= '0;
            best_weight <= '0;
            k_reg       <= '0;
            sel_reg     <= '0;
            sum_v_reg   <= '0;
            sum_w_reg   <= '0;
            max_w_reg   <= '0;
            min_v_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg   <= S_RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        found       <= 1'b0;
                        best_sel    <= '0;
                        best_value  <= '0;
                        best_weight <= '0;
                        k_reg       <= '0;
                        sel_reg     <= '0;
                        sum_v_reg   <= '0;
                        sum_w_reg   <= '0;
                        max_w_reg   <= max_weight;
                        min_v_reg   <= min_value;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Current candidate is dropped; partial best holds.
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else begin
                        if (better) begin
                            found       <= 1'b1;
                            best_sel    <= sel_reg;
                            best_value  <= sum_v_reg;
                            best_weight <= sum_w_reg;
                        end
                        if (k_reg == LAST_K) begin
                            state_reg <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            k_reg   <= k_next;
                            sel_reg <= sel_reg ^ (N'(1) << tz_idx);
                            if (!bit_now) begin
                                sum_v_reg <= sum_v_reg + item_v;
                                sum_w_reg <= sum_w_reg + item_w;
                            end else begin
                                sum_v_reg <= sum_v_reg - item_v;
                                sum_w_reg <= sum_w_reg - item_w;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knap_search.sv
// ---------------------------------------------------------------------------
// tb_knap_search
//
// Directed bench for knap_search with N=3. Expected final results are queued
// when a search is started and popped when done rises. While a search runs,
// every cycle's step count, selection and running sums are compared against
// values recomputed from the bench's own copy of the item tables. The running
// best is compared against a bench-side model of the candidates seen so far.
// ---------------------------------------------------------------------------
module tb_knap_search;

    localparam int N     = 3;
    localparam int IW    = 2;
    localparam int VAL_W = 8;
    localparam int SUM_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [IW-1:0]    cfg_idx;
    logic [VAL_W-1:0] cfg_value;
    logic [VAL_W-1:0] cfg_weight;
    logic [SUM_W-1:0] max_weight;
    logic [SUM_W-1:0] min_value;
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             found;
    logic [N-1:0]     best_sel;
    logic [SUM_W-1:0] best_value;
    logic [SUM_W-1:0] best_weight;

    knap_search #(.N(N), .IW(IW), .VAL_W(VAL_W), .SUM_W(SUM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_value  (cfg_value),
        .cfg_weight (cfg_weight),
        .max_weight (max_weight),
        .min_value  (min_value),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .best_sel   (best_sel),
        .best_value (best_value),
        .best_weight(best_weight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int found;
        int sel;
        int v;
        int w;
    } exp_t;

    exp_t sb_q[$];
    int   tb_v [N];
    int   tb_w [N];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int v, input int w);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_value = VAL_W'(v); cfg_weight = VAL_W'(w);
        tick();
        cfg_we = 1'b0;
        tb_v[idx] = v;
        tb_w[idx] = w;
    endtask

    function automatic int sum_of(input int sel, input bit use_w);
        int s = 0;
        for (int i = 0; i < N; i++)
            if (((sel >> i) & 1) == 1) s += use_w ? tb_w[i] : tb_v[i];
        return s;
    endfunction

    // Brute force over all selections in Gray order with direct summation.
    function automatic exp_t model_best(input int mw, input int mv);
        exp_t r = '{0, 0, 0, 0};
        for (int k = 0; k < (1 << N); k++) begin
            int s  = k ^ (k >> 1);
            int sv = sum_of(s, 1'b0);
            int sw = sum_of(s, 1'b1);
            if (sw <= mw && sv >= mv && (r.found == 0 || sv > r.v)) r = '{1, s, sv, sw};
        end
        return r;
    endfunction

    // Starts a search (any pending cfg write lands on the same edge) and
    // follows it cycle by cycle. abort_at >= 0 aborts in that RUN cycle.
    // poke injects a table write in RUN cycle 1 that must be ignored.
    task automatic run_search(input int mw, input int mv, input int abort_at, input bit poke);
        int   j;
        int   s;
        int   sv;
        int   sw;
        exp_t m;
        exp_t e;
        m = '{0, 0, 0, 0};
        max_weight = SUM_W'(mw);
        min_value  = SUM_W'(mv);
        start = 1'b1;
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
        j = 0;
        while (busy === 1'b1 && j < 64) begin
            s  = j ^ (j >> 1);
            sv = sum_of(s, 1'b0);
            sw = sum_of(s, 1'b1);
            check("step_k", 32'(dut.k_reg), j);
            check("step_sel", 32'(dut.sel_reg), s);
            check("step_sum_v", 32'(dut.sum_v_reg), sv);
            check("step_sum_w", 32'(dut.sum_w_reg), sw);
            check("run_found", 32'(found), m.found);
            check("run_best_sel", 32'(best_sel), m.sel);
            check("run_best_value", 32'(best_value), m.v);
            if (j == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                break;
            end
            if (poke && j == 1) begin
                cfg_we = 1'b1; cfg_idx = '0; cfg_value = 8'd200; cfg_weight = 8'd1;
            end
            tick();
            cfg_we = 1'b0;
            if (sw <= mw && sv >= mv && (m.found == 0 || sv > m.v)) m = '{1, s, sv, sw};
            j++;
        end
        if (abort_at >= 0) begin
            check("abort_busy", 32'(busy), 0);
            check("abort_done", 32'(done), 0);
            check("abort_best_weight", 32'(best_weight), m.w);
        end else begin
            check("busy_cycles", j, 1 << N);
            check("done_rise", 32'(done), 1);
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 32'(sb_q.size()), 1);
            end else begin
                e = sb_q.pop_front();
                check("final_found", 32'(found), e.found);
                check("final_best_sel", 32'(best_sel), e.sel);
                check("final_best_value", 32'(best_value), e.v);
                check("final_best_weight", 32'(best_weight), e.w);
            end
        end
    endtask

    initial begin
        exp_t r;
        int   rmw;
        int   rmv;
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_value = '0; cfg_weight = '0;
        max_weight = '0; min_value = '0; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < N; i++) begin tb_v[i] = 0; tb_w[i] = 0; end
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_found", 32'(found), 0);
        check("rst_best_sel", 32'(best_sel), 0);
        check("rst_best_value", 32'(best_value), 0);
        check("rst_best_weight", 32'(best_weight), 0);

        // Main case: 3'b001 must survive the tie with 3'b010 before 3'b100 wins
        load(0, 62, 79); load(1, 62, 40); load(2, 63, 62);
        sb_q.push_back('{1, 3'b100, 63, 62});
        run_search(100, 50, -1, 1'b0);
        $display("txn main: found=%0d sel=%b value=%0d weight=%0d", found, best_sel, best_value, best_weight);
        tick();
        check("done_hold", 32'(done), 1);
        check("done_hold_sel", 32'(best_sel), 3'b100);

        // Nothing qualifies; a write attempted mid-run must be ignored
        sb_q.push_back('{0, 0, 0, 0});
        run_search(100, 200, -1, 1'b1);
        $display("txn floor200: found=%0d sel=%b value=%0d", found, best_sel, best_value);

        // Zero weights and equality limit; item 2 written on the start edge
        load(0, 10, 0); load(1, 44, 0);
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_value = 8'd5; cfg_weight = 8'd7;
        tb_v[2] = 5; tb_w[2] = 7;
        sb_q.push_back('{1, 3'b011, 54, 0});
        run_search(0, 0, -1, 1'b0);
        $display("txn boundary: found=%0d sel=%b value=%0d weight=%0d", found, best_sel, best_value, best_weight);

        // Abort in RUN cycle 3, then a full restart
        load(0, 62, 79); load(1, 62, 40); load(2, 63, 62);
        run_search(100, 50, 3, 1'b0);
        check("abort_found", 32'(found), 1);
        check("abort_best_sel", 32'(best_sel), 3'b001);
        $display("txn abort: busy=%0d done=%0d found=%0d sel=%b", busy, done, found, best_sel);
        sb_q.push_back('{1, 3'b100, 63, 62});
        run_search(100, 50, -1, 1'b0);
        $display("txn restart: found=%0d sel=%b value=%0d", found, best_sel, best_value);

        // Random item set against the brute-force model
        for (int i = 0; i < N; i++) load(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        rmw = int'($urandom_range(0, 600));
        rmv = int'($urandom_range(0, 300));
        r = model_best(rmw, rmv);
        sb_q.push_back(r);
        run_search(rmw, rmv, -1, 1'b0);
        $display("txn random: max=%0d min=%0d found=%0d sel=%b value=%0d", rmw, rmv, found, best_sel, best_value);

        // Reset in the middle of a run
        max_weight = '0; min_value = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin tb_v[i] = 0; tb_w[i] = 0; end
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_found", 32'(found), 0);
        check("midrst_best_sel", 32'(best_sel), 0);
        check("midrst_best_value", 32'(best_value), 0);
        check("midrst_best_weight", 32'(best_weight), 0);
        $display("txn midrst: busy=%0d done=%0d found=%0d", busy, done, found);
        sb_q.push_back('{1, 0, 0, 0});
        run_search(0, 0, -1, 1'b0);
        $display("txn after_rst: found=%0d sel=%b value=%0d", found, best_sel, best_value);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
